// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and sizing helpers.
package mdu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REMU = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Counter must index 0..xlen-1.
    function automatic int cnt_width(input int xlen);
        return (xlen > 1) ? $clog2(xlen) : 1;
    endfunction

    localparam int CNT_W = cnt_width(XLEN_DEFAULT);

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for MUL, restoring shift-subtract for
// DIVU/REMU, both through the same XLEN+1-bit adder.
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,     // product accumulator / partial remainder
    input  logic [XLEN-1:0] sh,      // multiplier / dividend-quotient shifter
    input  logic [XLEN-1:0] opb,     // multiplicand / divisor
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] sh_nxt
);

    logic [XLEN:0] x, y, sum;
    logic          ge;

    // MUL walks the multiplier MSB-first, so the low XLEN bits of the
    // left-shifting accumulator are exactly the truncated product.
    assign x   = {acc, is_div ? sh[XLEN-1] : 1'b0};
    assign y   = is_div ? ~{1'b0, opb} : {1'b0, sh[XLEN-1] ? opb : {XLEN{1'b0}}};
    assign sum = x + y + {{XLEN{1'b0}}, is_div};

    // Partial remainder is below 2*divisor, so a negative difference always
    // sets the top bit and a non-negative one never does.
    assign ge = ~sum[XLEN];

    always_comb begin
        acc_nxt = sum[XLEN-1:0];
        sh_nxt  = {sh[XLEN-2:0], 1'b0};
        if (is_div) begin
            acc_nxt = ge ? sum[XLEN-1:0] : x[XLEN-1:0];
            sh_nxt  = {sh[XLEN-2:0], ge};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned MUL / DIVU / REMU unit, one bit per cycle, with a
// single-cycle register-file write-back pulse.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   operand_a,
    input  logic [XLEN-1:0]   operand_b,
    input  logic [REG_AW-1:0] dest_reg,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   result,
    output logic [REG_AW-1:0] result_reg,
    output logic              write_register_d
);

    localparam int CW = cnt_width(XLEN);

    state_e            state_q, state_d;
    op_e               op_q, op_in;
    logic [XLEN-1:0]   acc_q, sh_q, opb_q;
    logic [XLEN-1:0]   acc_nxt, sh_nxt;
    logic [CW-1:0]     cnt_q;
    logic [REG_AW-1:0] dest_q;
    logic [XLEN-1:0]   result_q, fin_res;
    logic [REG_AW-1:0] result_reg_q;
    logic              in_div, in_div0, last;

    assign op_in   = op_e'(op);
    assign in_div  = (op_in == OP_DIVU) || (op_in == OP_REMU);
    assign in_div0 = in_div && (operand_b == '0);
    assign last    = (cnt_q == CW'(XLEN - 1));

    mdu_step #(.XLEN(XLEN)) u_step (
        .is_div  ((op_q == OP_DIVU) || (op_q == OP_REMU)),
        .acc     (acc_q),
        .sh      (sh_q),
        .opb     (opb_q),
        .acc_nxt (acc_nxt),
        .sh_nxt  (sh_nxt)
    );

    always_comb begin
        fin_res = '0;
        case (op_q)
            OP_MUL:  fin_res = acc_nxt;
            OP_DIVU: fin_res = sh_nxt;
            OP_REMU: fin_res = acc_nxt;
            default: fin_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = in_div0 ? DONE : RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q         <= OP_MUL;
            acc_q        <= '0;
            sh_q         <= '0;
            opb_q        <= '0;
            cnt_q        <= '0;
            dest_q       <= '0;
            result_q     <= '0;
            result_reg_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_q   <= op_in;
                    acc_q  <= '0;
                    // Divide shifts the dividend out of sh; multiply shifts the multiplier.
                    sh_q   <= in_div ? operand_a : operand_b;
                    opb_q  <= in_div ? operand_b : operand_a;
                    cnt_q  <= '0;
                    dest_q <= dest_reg;
                    if (in_div0) begin
                        result_q     <= (op_in == OP_DIVU) ? {XLEN{1'b1}} : operand_a;
                        result_reg_q <= dest_reg;
                    end
                end
                RUN: begin
                    acc_q <= acc_nxt;
                    sh_q  <= sh_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        result_q     <= fin_res;
                        result_reg_q <= dest_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign write_register_d = done;
    assign result           = result_q;
    assign result_reg       = result_reg_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, randomized ops and
// hand-written sequences for busy-start, done-cycle start and mid-op reset.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_a = '0, operand_b = '0;
    logic [4:0]  dest_reg = '0;
    logic        busy, done, write_register_d;
    logic [31:0] result;
    logic [4:0]  result_reg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [4:0]  dest;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[10];

    mul_div_unit #(.XLEN(32), .REG_AW(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .op               (op),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .dest_reg         (dest_reg),
        .busy             (busy),
        .done             (done),
        .result           (result),
        .result_reg       (result_reg),
        .write_register_d (write_register_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (o)
            2'b00: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Drives a request for the coming edge and records what it must produce.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input logic [31:0] exp, input int lat);
        exp_t e;
        e.res = exp; e.rd = d; e.lat = lat;
        sb.push_back(e);
        op = o; operand_a = a; operand_b = b; dest_reg = d; start = 1'b1;
    endtask

    // Waits for done (counting cycles from n0) and checks it against the scoreboard.
    // With poke set, a divide-by-zero request is offered during the DONE cycle.
    task automatic finish_op(input int n0, input bit poke);
        int   n;
        exp_t e;
        n = n0;
        while (!done && n < 60) begin
            @(posedge clk); #1; n++;
            if (!done) chk("no_wb_before_done", {63'd0, write_register_d}, 64'd0);
        end
        e = sb.pop_front();
        if (!done) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            chk("latency", n, e.lat);
            chk("result", result, e.res);
            chk("result_reg", result_reg, e.rd);
            chk("wr_en", {63'd0, write_register_d}, 64'd1);
            chk("busy_in_done", {63'd0, busy}, 64'd1);
            if (poke) begin
                op = 2'b01; operand_a = 32'd8; operand_b = 32'd0; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk("done_single", {63'd0, done}, 64'd0);
            chk("idle_after", {63'd0, busy}, 64'd0);
            chk("result_hold", result, e.res);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input logic [31:0] exp, input int lat);
        @(negedge clk);
        launch(o, a, b, d, exp, lat);
        @(posedge clk); #1;
        start = 1'b0;
        finish_op(1, 1'b0);
    endtask

    initial begin
        int n, extra;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        tbl[0] = '{2'b00, 32'd7,          32'd6,       5'd3,  32'd42,          33};
        tbl[1] = '{2'b00, 32'hFFFF_FFFF,  32'd2,       5'd4,  32'hFFFF_FFFE,   33};
        tbl[2] = '{2'b01, 32'd100,        32'd7,       5'd5,  32'd14,          33};
        tbl[3] = '{2'b10, 32'd100,        32'd7,       5'd6,  32'd2,           33};
        tbl[4] = '{2'b01, 32'd5,          32'd0,       5'd7,  32'hFFFF_FFFF,   1};
        tbl[5] = '{2'b10, 32'd5,          32'd0,       5'd8,  32'd5,           1};
        tbl[6] = '{2'b11, 32'd123,        32'd456,     5'd9,  32'd0,           33};
        tbl[7] = '{2'b01, 32'hFFFF_FFFF,  32'd1,       5'd31, 32'hFFFF_FFFF,   33};
        tbl[8] = '{2'b10, 32'd7,          32'd9,       5'd1,  32'd7,           33};
        tbl[9] = '{2'b00, 32'h0001_0000,  32'h0001_0000, 5'd2, 32'd0,          33};

        // Reset state, with start held to confirm reset wins.
        start = 1'b1; operand_a = 32'd1; operand_b = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_wr_en", {63'd0, write_register_d}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_result_reg", result_reg, 64'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dest, tbl[i].exp, tbl[i].lat);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 2));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 5000));
            run_op(ro, ra, rb, 5'(i + 10), model(ro, ra, rb), (ro != 2'b00 && rb == 0) ? 1 : 33);
        end

        // A new request at cycle 10 of a busy MUL must be dropped.
        @(negedge clk);
        launch(2'b00, 32'd3, 32'd4, 5'd12, 32'd12, 33);
        @(posedge clk); #1;
        start = 1'b0; n = 1;
        while (n < 10) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        op = 2'b01; operand_a = 32'd99; operand_b = 32'd0; dest_reg = 5'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n++;
        finish_op(n, 1'b0);
        extra = 0;
        repeat (40) begin @(posedge clk); #1; if (done) extra++; end
        chk("dropped_req_no_done", extra, 0);

        // Start during the DONE cycle is ignored.
        @(negedge clk);
        launch(2'b00, 32'd5, 32'd5, 5'd13, 32'd25, 33);
        @(posedge clk); #1;
        start = 1'b0;
        finish_op(1, 1'b1);
        @(posedge clk); #1;
        chk("done_cycle_start_ignored", {63'd0, done}, 64'd0);

        // Reset at cycle 15 of DIVU aborts with no write-back.
        @(negedge clk);
        op = 2'b01; operand_a = 32'd1000; operand_b = 32'd7; dest_reg = 5'd15; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n = 1;
        while (n < 15) begin @(posedge clk); #1; n++; end
        chk("busy_mid_run", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_wr_en", {63'd0, write_register_d}, 64'd0);
        chk("abort_result", result, 64'd0);
        @(posedge clk); #1;
        chk("abort_still_idle", {63'd0, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        launch(2'b01, 32'd9, 32'd3, 5'd16, 32'd3, 33);
        @(posedge clk); #1;
        start = 1'b0;
        chk("accept_after_reset", {63'd0, busy}, 64'd1);
        finish_op(1, 1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
